// File: rtl/spi2_cmd_slave.sv
// rtl/spi2_cmd_slave.sv - SPI2 16-bit word command slave driving the memory request bus
// Burst commands 0xD0/0xD1 are decoded only when SPI2_BURST_EN is defined.
module spi2_cmd_slave #(
   parameter logic [15:0] ID_VALUE    = 16'hC4B5,
   parameter int          SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        spi_sck,
   input  logic        spi_cs,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic [31:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_wr,
   output logic        mem_rd,
   input  logic        mem_busy,
   input  logic [15:0] mem_rdata,
   input  logic        mem_rvalid
);

`ifdef SPI2_BURST_EN
   localparam bit BURST_EN = 1'b1;
`else
   localparam bit BURST_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE, REG_RD, ADDR_LO, ADDR_HI, DUMMY, DATA, BLEN, BDATA
   } state_t;

   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic        sck_prev_q, sck_prev_d;
   logic        cs_prev_q, cs_prev_d;
   state_t      state_q, state_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic [14:0] rx_sh_q, rx_sh_d;
   logic [15:0] tx_q, tx_d;
   logic [7:0]  reg_addr_q, reg_addr_d;
   logic        is_wr_q, is_wr_d;
   logic        burst_q, burst_d;
   logic        acc_done_q, acc_done_d;
   logic [15:0] blen_q, blen_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [15:0] mem_wdata_q, mem_wdata_d;
   logic        mem_wr_q, mem_wr_d;
   logic        mem_rd_q, mem_rd_d;
   logic        wr_pend_q, wr_pend_d;
   logic        rd_pend_q, rd_pend_d;
   logic        rd_wait_q, rd_wait_d;
   logic [15:0] rd_latch_q, rd_latch_d;
   logic        err_q, err_d;

   logic        sck_s, cs_s, mosi_s;
   logic        sck_rise, sck_fall, cs_fall, word_done;
   logic [15:0] word;
   logic [31:0] acc_addr;
   logic [15:0] reg_val, resp;
   logic        resp_late;

   assign sck_s     = sck_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sck_rise  = sck_s & ~sck_prev_q;
   assign sck_fall  = ~sck_s & sck_prev_q;
   assign cs_fall   = ~cs_s & cs_prev_q;
   assign word_done = sck_rise & ~cs_s & (bit_cnt_q == 5'd15);
   assign word      = {rx_sh_q, mosi_s};
   // Burst accesses after the first one move to the next word address.
   assign acc_addr  = acc_done_q ? mem_addr_q + 32'd1 : mem_addr_q;

   assign spi_miso  = tx_q[0];
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wr    = mem_wr_q;
   assign mem_rd    = mem_rd_q;

   always_comb begin
      reg_val = 16'h0000;
      case (reg_addr_q)
         8'd0:    reg_val = ID_VALUE;
         8'd1:    reg_val = {14'b0, err_q, wr_pend_q | rd_pend_q};
         8'd4:    reg_val = rd_latch_q;
         default: reg_val = 16'h0000;
      endcase
   end

   // A word that must return read data it does not yet have answers 0xFFFF.
   always_comb begin
      resp      = 16'h0000;
      resp_late = 1'b0;
      if (state_q == REG_RD) begin
         if (reg_addr_q == 8'd4 && rd_wait_q) resp_late = 1'b1;
         else                                 resp      = reg_val;
      end else if (state_q == BDATA && !is_wr_q) begin
         if (rd_wait_q) resp_late = 1'b1;
         else           resp      = rd_latch_q;
      end
      if (resp_late) resp = 16'hFFFF;
   end

   always_comb begin
      sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sck_prev_d  = sck_s;
      cs_prev_d   = cs_s;
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_sh_d     = rx_sh_q;
      tx_d        = tx_q;
      reg_addr_d  = reg_addr_q;
      is_wr_d     = is_wr_q;
      burst_d     = burst_q;
      acc_done_d  = acc_done_q;
      blen_d      = blen_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wr_d    = 1'b0;
      mem_rd_d    = 1'b0;
      wr_pend_d   = wr_pend_q;
      rd_pend_d   = rd_pend_q;
      rd_wait_d   = rd_wait_q;
      rd_latch_d  = rd_latch_q;
      err_d       = err_q;

      if (cs_s) begin
         bit_cnt_d = 5'd0;
      end else if (sck_rise) begin
         rx_sh_d   = {rx_sh_q[13:0], mosi_s};
         bit_cnt_d = (bit_cnt_q == 5'd15) ? 5'd0 : bit_cnt_q + 5'd1;
      end

      if (cs_fall) begin
         tx_d = resp;
         if (resp_late) err_d = 1'b1;
      end else if (sck_fall && !cs_s) begin
         tx_d = {1'b0, tx_q[15:1]};
      end

      if (wr_pend_q && !mem_busy) begin
         mem_wr_d  = 1'b1;
         wr_pend_d = 1'b0;
      end
      if (rd_pend_q && !mem_busy) begin
         mem_rd_d  = 1'b1;
         rd_pend_d = 1'b0;
      end
      if (mem_rvalid) begin
         rd_latch_d = mem_rdata;
         rd_wait_d  = 1'b0;
      end

      if (word_done) begin
         case (state_q)
            IDLE: begin
               if (word[15:8] == 8'h80) begin
                  reg_addr_d = word[7:0];
                  state_d    = REG_RD;
               end else if (word[15:8] == 8'hC0 || word[15:8] == 8'hC1) begin
                  is_wr_d    = word[8];
                  burst_d    = 1'b0;
                  acc_done_d = 1'b0;
                  state_d    = ADDR_LO;
               end else if (BURST_EN && (word[15:8] == 8'hD0 || word[15:8] == 8'hD1)) begin
                  is_wr_d    = word[8];
                  burst_d    = 1'b1;
                  acc_done_d = 1'b0;
                  state_d    = BLEN;
               end
            end
            REG_RD: state_d = IDLE;
            BLEN: begin
               blen_d  = word;
               state_d = ADDR_LO;
            end
            ADDR_LO: begin
               mem_addr_d = {mem_addr_q[31:16], word};
               state_d    = ADDR_HI;
            end
            ADDR_HI: begin
               mem_addr_d = {word, mem_addr_q[15:0]};
               if (!is_wr_q)           state_d = DUMMY;
               else if (!burst_q)      state_d = DATA;
               else if (blen_q == 16'd0) state_d = IDLE;
               else                    state_d = BDATA;
            end
            DUMMY: begin
               if (burst_q && blen_q == 16'd0) begin
                  state_d = IDLE;
               end else begin
                  rd_pend_d  = 1'b1;
                  rd_wait_d  = 1'b1;
                  acc_done_d = 1'b1;
                  state_d    = burst_q ? BDATA : IDLE;
               end
            end
            DATA: begin
               mem_wdata_d = word;
               wr_pend_d   = 1'b1;
               state_d     = IDLE;
            end
            BDATA: begin
               blen_d = blen_q - 16'd1;
               if (is_wr_q) begin
                  mem_addr_d  = acc_addr;
                  mem_wdata_d = word;
                  wr_pend_d   = 1'b1;
                  acc_done_d  = 1'b1;
               end else if (blen_q != 16'd1) begin
                  mem_addr_d = acc_addr;
                  rd_pend_d  = 1'b1;
                  rd_wait_d  = 1'b1;
               end
               if (blen_q == 16'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_sync_q  <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sck_prev_q  <= 1'b0;
         cs_prev_q   <= 1'b1;
         state_q     <= IDLE;
         bit_cnt_q   <= 5'd0;
         rx_sh_q     <= 15'd0;
         tx_q        <= 16'd0;
         reg_addr_q  <= 8'd0;
         is_wr_q     <= 1'b0;
         burst_q     <= 1'b0;
         acc_done_q  <= 1'b0;
         blen_q      <= 16'd0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 16'd0;
         mem_wr_q    <= 1'b0;
         mem_rd_q    <= 1'b0;
         wr_pend_q   <= 1'b0;
         rd_pend_q   <= 1'b0;
         rd_wait_q   <= 1'b0;
         rd_latch_q  <= 16'd0;
         err_q       <= 1'b0;
      end else begin
         sck_sync_q  <= sck_sync_d;
         cs_sync_q   <= cs_sync_d;
         mosi_sync_q <= mosi_sync_d;
         sck_prev_q  <= sck_prev_d;
         cs_prev_q   <= cs_prev_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_sh_q     <= rx_sh_d;
         tx_q        <= tx_d;
         reg_addr_q  <= reg_addr_d;
         is_wr_q     <= is_wr_d;
         burst_q     <= burst_d;
         acc_done_q  <= acc_done_d;
         blen_q      <= blen_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wr_q    <= mem_wr_d;
         mem_rd_q    <= mem_rd_d;
         wr_pend_q   <= wr_pend_d;
         rd_pend_q   <= rd_pend_d;
         rd_wait_q   <= rd_wait_d;
         rd_latch_q  <= rd_latch_d;
         err_q       <= err_d;
      end
   end

endmodule
